// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding imem reads and
// holds each fetched word until the controller accepts it.
//   state  | meaning
//   S_IDLE | dead cycle after reset release
//   S_REQ  | imem_rd pulse at imem_addr = pc
//   S_WAIT | waiting for imem_rvalid (kill drops the response)
//   S_HOLD | presenting a valid instruction until stall drops
module instr_fetch_unit #(
  parameter logic [31:0] PC_START  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_pc,
  input  logic [1:0]  sel_pc,
  input  logic [31:0] branch_target,
  input  logic [31:0] reg_pc,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic [31:0] r_imem_addr;
  logic        r_imem_rd;
  logic [31:0] r_instr_out;
  logic        r_instr_valid;
  logic [31:0] r_instr_pc;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_raw;
  logic [31:0] w_redirect;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_redirect_raw = w_pc_plus4;
    case (sel_pc)
      2'b00:   w_redirect_raw = w_pc_plus4;
      2'b01:   w_redirect_raw = PC_START;
      2'b10:   w_redirect_raw = branch_target;
      default: w_redirect_raw = reg_pc;
    endcase
  end

  // Redirect targets are always word aligned.
  assign w_redirect = {w_redirect_raw[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_START;
      r_kill        <= 1'b0;
      r_imem_addr   <= PC_START;
      r_imem_rd     <= 1'b0;
      r_instr_out   <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= 32'h0;
    end else begin
      r_imem_rd <= 1'b0;
      if (load_pc) begin
        r_pc          <= w_redirect;
        r_instr_valid <= 1'b0;
        r_instr_out   <= NOP_INSTR;
        case (r_state)
          S_REQ: begin
            // The old-address request is already on the bus; drop its reply.
            r_kill  <= 1'b1;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              r_kill      <= 1'b0;
              r_state     <= S_REQ;
              r_imem_rd   <= 1'b1;
              r_imem_addr <= w_redirect;
            end else begin
              r_kill <= 1'b1;
            end
          end
          default: begin
            r_kill      <= 1'b0;
            r_state     <= S_REQ;
            r_imem_rd   <= 1'b1;
            r_imem_addr <= w_redirect;
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_REQ;
            r_imem_rd   <= 1'b1;
            r_imem_addr <= r_pc;
          end
          S_REQ: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (r_kill) begin
                r_kill      <= 1'b0;
                r_state     <= S_REQ;
                r_imem_rd   <= 1'b1;
                r_imem_addr <= r_pc;
              end else begin
                r_instr_out   <= imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= w_pc_plus4;
                r_state       <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_instr_valid <= 1'b0;
              r_instr_out   <= NOP_INSTR;
              r_state       <= S_REQ;
              r_imem_rd     <= 1'b1;
              r_imem_addr   <= r_pc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_addr   = r_imem_addr;
  assign imem_rd     = r_imem_rd;
  assign instr_out   = r_instr_out;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;
  assign pc          = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed redirects, stalls, kills,
// PC wrap and async reset against a latency-programmable instruction memory.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_pc = 1'b0;
  logic [1:0]  sel_pc = 2'b00;
  logic [31:0] branch_target = '0;
  logic [31:0] reg_pc = '0;
  logic        stall = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        imem_rvalid = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] pc;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .load_pc(load_pc), .sel_pc(sel_pc),
    .branch_target(branch_target), .reg_pc(reg_pc), .stall(stall),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .imem_rvalid(imem_rvalid), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] tag;
    logic [31:0] pc_after;
  } exp_instr_t;

  logic [31:0] req_q[$];
  exp_instr_t  ins_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          lat     = 1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1005;
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    n_total++;
    $display("FAIL %s: instr_valid timeout got 0 expected 1", name);
  endtask

  // Instruction memory: response appears lat cycles after the request cycle.
  initial begin
    int          cnt;
    logic [31:0] a_q;
    cnt = 0;
    a_q = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(a_q);
          end
        end
        if (imem_rd) begin
          cnt = lat;
          a_q = imem_addr;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a read or presents a word.
  initial begin
    logic       prev_v;
    exp_instr_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_rd) begin
          if (req_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_rd: got addr %h expected no request", imem_addr);
          end else begin
            chk("req_addr", imem_addr, req_q.pop_front());
          end
        end
        if (instr_valid && !prev_v) begin
          if (ins_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid: got instr %h pc %h expected none", instr_out, instr_pc);
          end else begin
            e = ins_q.pop_front();
            chk("instr_out", instr_out, e.word);
            chk("instr_pc", instr_pc, e.tag);
            chk("pc_after_fetch", pc, e.pc_after);
          end
        end
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_rd", {31'b0, imem_rd}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // First fetch, latency 1
    lat = 1;
    req_q.push_back(32'h0);
    ins_q.push_back('{memword(32'h0), 32'h0, 32'h4});
    rst = 1'b0;
    chk("idle_no_rd", {31'b0, imem_rd}, 32'd0);
    @(negedge clk);
    chk("first_rd", {31'b0, imem_rd}, 32'd1);
    wait_valid("first_fetch");

    // Stall holds the word
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_instr", instr_out, 32'hE3A0_1005);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_no_rd", {31'b0, imem_rd}, 32'd0);
    end
    req_q.push_back(32'h4);
    ins_q.push_back('{memword(32'h4), 32'h4, 32'h8});
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_valid", {31'b0, instr_valid}, 32'd0);
    chk("unstall_nop", instr_out, NOP);
    chk("unstall_rd", {31'b0, imem_rd}, 32'd1);
    stall = 1'b1;
    wait_valid("fetch_4");

    // Branch in 2nd WAIT cycle kills the in-flight fetch, latency 4
    lat = 4;
    req_q.push_back(32'h8);
    req_q.push_back(32'h100);
    ins_q.push_back('{memword(32'h100), 32'h100, 32'h104});
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_pc = 1'b1; sel_pc = 2'b10; branch_target = 32'h100;
    @(negedge clk);
    load_pc = 1'b0;
    chk("kill_pc", pc, 32'h100);
    chk("kill_valid", {31'b0, instr_valid}, 32'd0);
    wait_valid("fetch_100");

    // reg_pc redirect coinciding with rvalid, latency 2, unaligned target
    lat = 2;
    req_q.push_back(32'h104);
    req_q.push_back(32'h200);
    ins_q.push_back('{memword(32'h200), 32'h200, 32'h204});
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_pc = 1'b1; sel_pc = 2'b11; reg_pc = 32'h203;
    @(negedge clk);
    load_pc = 1'b0;
    chk("regpc_pc", pc, 32'h200);
    chk("regpc_valid", {31'b0, instr_valid}, 32'd0);
    wait_valid("fetch_200");

    // Branch to top of memory from HOLD (stall ignored), pc wraps
    lat = 1;
    req_q.push_back(32'hFFFF_FFFC);
    ins_q.push_back('{memword(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0});
    load_pc = 1'b1; sel_pc = 2'b10; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    load_pc = 1'b0;
    chk("wrap_redirect_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_redirect_valid", {31'b0, instr_valid}, 32'd0);
    wait_valid("fetch_top");
    req_q.push_back(32'h0);
    ins_q.push_back('{memword(32'h0), 32'h0, 32'h4});
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    wait_valid("fetch_after_wrap");

    // sel_pc = 00 redirect: pc + 4 from pc = 4
    req_q.push_back(32'h8);
    ins_q.push_back('{memword(32'h8), 32'h8, 32'hC});
    load_pc = 1'b1; sel_pc = 2'b00;
    @(negedge clk);
    load_pc = 1'b0;
    chk("seq_redirect_pc", pc, 32'h8);
    wait_valid("fetch_8");

    // Async reset during WAIT
    lat = 4;
    req_q.push_back(32'hC);
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_instr", instr_out, NOP);
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_rd", {31'b0, imem_rd}, 32'd0);
    repeat (2) @(negedge clk);
    lat = 1;
    req_q.push_back(32'h0);
    ins_q.push_back('{memword(32'h0), 32'h0, 32'h4});
    rst = 1'b0;
    wait_valid("fetch_after_reset");

    repeat (4) @(negedge clk);
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("ins_q_empty", ins_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
